// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Iterative 32-bit multiply/divide unit with HI/LO result registers.
//   Multiply uses radix-2 shift-add; divide uses radix-2 restoring
//   shift-subtract. One step per cycle, 32 steps, then a fix-up cycle.
//
// Ports
//   Clk        in   clock, rising edge
//   Rst_n      in   asynchronous active-low reset
//   Start      in   begin operation selected by Op (ignored while Busy)
//   Op[1:0]    in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   OperandA   in   multiplicand / dividend / MTHI-MTLO data
//   OperandB   in   multiplier / divisor
//   WriteHi    in   load Hi from OperandA (IDLE only, Start has priority)
//   WriteLo    in   load Lo from OperandA (IDLE only, Start has priority)
//   Hi, Lo     out  result registers
//   Busy       out  high in RUN and FINISH
//   Done       out  one-cycle pulse when Hi/Lo take a new result
//   DivByZero  out  one-cycle pulse with Done for a divide by zero
//   DbgState   out  current FSM state (0 IDLE, 1 RUN, 2 FINISH)
//
// Handshake: Start is a single-cycle request sampled only when Busy=0;
// there is no backpressure and nothing is queued. The result is
// signalled by Done, which is valid for exactly one cycle.
// ---------------------------------------------------------------------------
module mult_div_unit (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] OperandA,
    input  logic [31:0] OperandB,
    input  logic        WriteHi,
    input  logic        WriteLo,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        Busy,
    output logic        Done,
    output logic        DivByZero,
    output logic [1:0]  DbgState
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic [31:0] m_q, m_d;       // multiplicand or divisor magnitude
    logic [31:0] wh_q, wh_d;     // partial product high / partial remainder
    logic [31:0] wl_q, wl_d;     // multiplier-product low / dividend-quotient
    logic        neg_q, neg_d;   // negate product or quotient at fix-up
    logic        rneg_q, rneg_d; // negate remainder at fix-up
    logic        dbz_q, dbz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        dz_q, dz_d;

    // Operand signs only matter for the signed ops (Op[0]==0).
    logic        sign_a, sign_b;
    logic [31:0] mag_a, mag_b;
    assign sign_a = ~Op[0] & OperandA[31];
    assign sign_b = ~Op[0] & OperandB[31];
    assign mag_a  = sign_a ? (32'd0 - OperandA) : OperandA;
    assign mag_b  = sign_b ? (32'd0 - OperandB) : OperandB;

    // Multiply step: add multiplicand when multiplier LSB is set, then
    // shift the 65-bit {carry, hi, lo} right by one.
    logic [32:0] mul_sum;
    assign mul_sum = {1'b0, wh_q} + (wl_q[0] ? {1'b0, m_q} : 33'd0);

    // Divide step: shift next dividend bit into the remainder and try a
    // subtract; a borrow in bit 32 means restore (keep the shifted value).
    logic [32:0] div_shift, div_diff;
    assign div_shift = {wh_q, wl_q[31]};
    assign div_diff  = div_shift - {1'b0, m_q};

    logic [63:0] prod_fix;
    logic [31:0] quot_fix, rem_fix;
    assign prod_fix = neg_q  ? (64'd0 - {wh_q, wl_q}) : {wh_q, wl_q};
    assign quot_fix = neg_q  ? (32'd0 - wl_q) : wl_q;
    assign rem_fix  = rneg_q ? (32'd0 - wh_q) : wh_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        m_d      = m_q;
        wh_d     = wh_q;
        wl_d     = wl_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dbz_d    = dbz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    is_div_d = Op[1];
                    cnt_d    = 5'd0;
                    neg_d    = sign_a ^ sign_b;
                    rneg_d   = Op[1] & sign_a;
                    dbz_d    = 1'b0;
                    wh_d     = 32'd0;
                    if (Op[1] && (OperandB == 32'd0)) begin
                        // Divide by zero: result is staged raw, FINISH
                        // passes it through without fix-up.
                        wh_d    = OperandA;
                        wl_d    = 32'hFFFF_FFFF;
                        neg_d   = 1'b0;
                        rneg_d  = 1'b0;
                        dbz_d   = 1'b1;
                        state_d = S_FINISH;
                    end else if (Op[1]) begin
                        wl_d    = mag_a;
                        m_d     = mag_b;
                        state_d = S_RUN;
                    end else begin
                        wl_d    = mag_b;
                        m_d     = mag_a;
                        state_d = S_RUN;
                    end
                end else begin
                    if (WriteHi) hi_d = OperandA;
                    if (WriteLo) lo_d = OperandA;
                end
            end
            S_RUN: begin
                if (!is_div_q) begin
                    wh_d = mul_sum[32:1];
                    wl_d = {mul_sum[0], wl_q[31:1]};
                end else if (!div_diff[32]) begin
                    wh_d = div_diff[31:0];
                    wl_d = {wl_q[30:0], 1'b1};
                end else begin
                    wh_d = div_shift[31:0];
                    wl_d = {wl_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FINISH;
            end
            S_FINISH: begin
                if (dbz_q) begin
                    hi_d = wh_q;
                    lo_d = wl_q;
                end else if (!is_div_q) begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end else begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end
                done_d  = 1'b1;
                dz_d    = dbz_q;
                cnt_d   = 5'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            is_div_q <= 1'b0;
            m_q      <= 32'd0;
            wh_q     <= 32'd0;
            wl_q     <= 32'd0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            m_q      <= m_d;
            wh_q     <= wh_d;
            wl_q     <= wl_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dbz_q    <= dbz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign Hi        = hi_q;
    assign Lo        = lo_q;
    assign Busy      = (state_q != S_IDLE);
    assign Done      = done_q;
    assign DivByZero = dz_q;
    assign DbgState  = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//   Directed-vector bench for mult_div_unit. Drivers push the expected
//   {done cycle, DivByZero, Hi, Lo} into exp_q when a Start is issued; a
//   monitor on the falling edge pops and compares whenever Done is seen.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // ---------------- clock / reset ----------------
    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [31:0] OperandA = 32'd0;
    logic [31:0] OperandB = 32'd0;
    logic        WriteHi = 1'b0;
    logic        WriteLo = 1'b0;
    logic [31:0] Hi, Lo;
    logic        Busy, Done, DivByZero;
    logic [1:0]  DbgState;

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    mult_div_unit dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Start    (Start),
        .Op       (Op),
        .OperandA (OperandA),
        .OperandB (OperandB),
        .WriteHi  (WriteHi),
        .WriteLo  (WriteLo),
        .Hi       (Hi),
        .Lo       (Lo),
        .Busy     (Busy),
        .Done     (Done),
        .DivByZero(DivByZero),
        .DbgState (DbgState)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [96:0] exp_q[$];  // {done_cycle[31:0], dbz, hi[31:0], lo[31:0]}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (Rst_n) begin
            if (Done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got Done=1 expected none (cyc=%0d)", cyc);
                end else begin
                    logic [96:0] e;
                    e = exp_q.pop_front();
                    check("done_cycle", cyc, e[96:65]);
                    check("div_by_zero", {31'd0, DivByZero}, {31'd0, e[64]});
                    check("hi", Hi, e[63:32]);
                    check("lo", Lo, e[31:0]);
                end
            end else if (DivByZero) begin
                total++;
                bad++;
                $display("FAIL dbz_without_done: got DivByZero=1 expected 0 (cyc=%0d)", cyc);
            end
        end
    end

    // ---------------- drivers ----------------
    // Drive inputs for one cycle starting at the current falling edge;
    // the next rising edge is T0.
    task automatic drive_now(input logic st, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic wh, input logic wl,
                             input logic push, input logic [31:0] ehi,
                             input logic [31:0] elo, input logic edbz);
        int lat;
        Start = st; Op = op; OperandA = a; OperandB = b; WriteHi = wh; WriteLo = wl;
        lat = (op[1] && b == 32'd0) ? 1 : 33;
        if (push) exp_q.push_back({32'(cyc + 1 + lat), edbz, ehi, elo});
        @(negedge Clk);
        Start = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic push, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edbz);
        @(negedge Clk);
        drive_now(1'b1, op, a, b, 1'b0, 1'b0, push, ehi, elo, edbz);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!Busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge Clk);
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL wait_idle: got Busy=1 after 100 cycles expected 0");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        #12;
        check("rst_hi", Hi, 32'd0);
        check("rst_lo", Lo, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_dbz", {31'd0, DivByZero}, 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;

        // MULT -3 * 7 with Busy profile over the whole operation
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        for (int i = 0; i < 33; i++) begin
            check("busy_active", {31'd0, Busy}, 32'd1);
            @(negedge Clk);
        end
        check("busy_after_done", {31'd0, Busy}, 32'd0);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        wait_idle();
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        wait_idle();
        issue(OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0);
        wait_idle();
        issue(OP_DIVU, 32'h0000_1234, 32'd0, 1'b1, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
        wait_idle();
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0);
        wait_idle();
        issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'd0, 1'b0);
        wait_idle();
        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'd1, 32'hFFFF_FFFD, 1'b0);
        wait_idle();
        issue(OP_DIV, 32'd0, 32'd5, 1'b1, 32'd0, 32'd0, 1'b0);
        wait_idle();
        issue(OP_DIV, 32'hFFFF_FFF0, 32'd0, 1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);
        wait_idle();

        // MTHI + MTLO together in IDLE
        @(negedge Clk);
        drive_now(1'b0, OP_MULT, 32'hCAFE_F00D, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        check("mthi_mtlo_hi", Hi, 32'hCAFE_F00D);
        check("mthi_mtlo_lo", Lo, 32'hCAFE_F00D);

        // Start with WriteHi in the same cycle: write dropped, Hi held in RUN
        @(negedge Clk);
        drive_now(1'b1, OP_MULTU, 32'd16, 32'd16, 1'b1, 1'b0, 1'b1, 32'd0, 32'h100, 1'b0);
        check("start_beats_writehi", Hi, 32'hCAFE_F00D);
        repeat (10) @(negedge Clk);
        check("hi_held_in_run", Hi, 32'hCAFE_F00D);
        wait_idle();

        // Start and WriteLo while busy are ignored
        issue(OP_MULTU, 32'd5, 32'd6, 1'b1, 32'd0, 32'd30, 1'b0);
        repeat (9) @(negedge Clk);
        drive_now(1'b1, OP_MULTU, 32'd9, 32'd9, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        check("writelo_ignored_busy", Lo, 32'h100);
        check("still_busy", {31'd0, Busy}, 32'd1);
        wait_idle();
        repeat (3) @(negedge Clk);

        // Reset mid-RUN aborts without a Done
        @(negedge Clk);
        drive_now(1'b0, OP_MULT, 32'h55AA_55AA, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (5) @(negedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        check("async_rst_hi", Hi, 32'd0);
        check("async_rst_lo", Lo, 32'd0);
        check("async_rst_busy", {31'd0, Busy}, 32'd0);
        check("async_rst_done", {31'd0, Done}, 32'd0);
        repeat (2) @(negedge Clk);
        // Release and request on the same falling edge: accepted at the
        // first rising edge after reset.
        Rst_n = 1'b1;
        drive_now(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 1'b1, 32'd2, 32'd14, 1'b0);
        wait_idle();
        repeat (40) @(negedge Clk);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have no parameters; all datapaths SHALL be fixed at 32 bits.
REQ-002 Clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-003 Rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Start  input  1  one-cycle request to begin the operation selected by Op.
REQ-005 Op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 OperandA  input  32  rs value (multiplicand/dividend), taken from register-file ReadData1.
REQ-007 OperandB  input  32  rt value (multiplier/divisor), taken from register-file ReadData2.
REQ-008 WriteHi  input  1  MTHI strobe: load Hi from OperandA.
REQ-009 WriteLo  input  1  MTLO strobe: load Lo from OperandA.
REQ-010 Hi  output  32  HI register: high product word or remainder.
REQ-011 Lo  output  32  LO register: low product word or quotient.
REQ-012 Busy  output  1  high while an operation is in progress.
REQ-013 Done  output  1  one-cycle pulse when Hi/Lo take a new result.
REQ-014 DivByZero  output  1  one-cycle pulse, coincident with Done, for DIV/DIVU with OperandB=0.

Function
REQ-015 States SHALL be IDLE, RUN and FINISH; Busy SHALL be 1 in RUN and FINISH and 0 in IDLE.
REQ-016 In IDLE, when Start=1 at edge T0, the block SHALL latch Op, the operand magnitudes (signed ops) or raw operands (unsigned ops), and the result signs, then enter RUN with iteration counter 0.
REQ-017 RUN SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide; after 32 steps (edges T1..T32) it SHALL enter FINISH.
REQ-018 At edge T33, FINISH SHALL apply sign fix-up, write Hi/Lo, pulse Done and return to IDLE; total latency from Start to a valid result SHALL be 33 cycles.
REQ-019 Multiply: {Hi,Lo} SHALL be the full 64-bit product; for MULT it SHALL be negated when the operand signs differ.
REQ-020 Divide: Lo SHALL be the quotient and Hi the remainder; for DIV the quotient sign SHALL be signA^signB and the remainder sign SHALL equal the dividend sign.
REQ-021 DIV of 0x80000000 by 0xFFFFFFFF SHALL give Lo=0x80000000 and Hi=0 with no flag.
REQ-022 A divide with OperandB=0 SHALL skip RUN and go IDLE->FINISH, giving Hi=OperandA, Lo=0xFFFFFFFF, Done=1 and DivByZero=1 at edge T1.
REQ-023 Start, WriteHi and WriteLo SHALL be ignored while Busy=1; requests are not queued.
REQ-024 In IDLE, WriteHi and WriteLo SHALL update their register at the next edge; if both are asserted, both SHALL load OperandA.
REQ-025 In IDLE, Start SHALL take priority over WriteHi/WriteLo asserted in the same cycle; the writes SHALL be dropped.
REQ-026 Hi and Lo SHALL hold their values between updates, including throughout RUN.
REQ-027 Done and DivByZero SHALL be registered outputs, high for exactly one cycle.

Reset
REQ-028 When Rst_n=0, the block SHALL immediately force state=IDLE, Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0 and counter=0, without waiting for Clk.
REQ-029 A reset asserted during RUN or FINISH SHALL abort the operation; no Done pulse SHALL follow it.
REQ-030 After Rst_n deasserts, the first Start SHALL be accepted on the first rising edge.

Verification
REQ-031 MULT with A=0xFFFFFFFD (-3) and B=7 -> Done at T33; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; Busy high for T1..T33 only.
REQ-032 MULTU with A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
REQ-033 DIV with A=-7 and B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIVU with A=100 and B=7 -> Lo=14, Hi=2.
REQ-034 DIVU with A=0x1234 and B=0 -> at T1 Done=DivByZero=1, Hi=0x1234, Lo=0xFFFFFFFF.
REQ-035 Start with A=5 and B=6 (MULTU), then Start with A=9 and WriteLo at T10 -> both ignored; result Lo=30; Rst_n pulsed low mid-RUN -> Hi=Lo=0 at once and no Done.
REQ-036 In IDLE, WriteHi=WriteLo=1 with A=0xCAFEF00D -> Hi=Lo=0xCAFEF00D at the next edge; Start plus WriteHi in the same cycle -> Hi unchanged until the result is written.
